// File: rtl/if1_pc_gen.sv
// IF1 fetch-address generator: holds the fetch PC, picks the next PC and issues instruction fetches.
// Optional IF1_BP_EN: when defined, predictor taken/target steer the next PC and are tagged to IF2.
module if1_pc_gen #(
  parameter logic [31:0] RESET_PC        = 32'h1C000000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [5:0]  bp_pc_low,
  input  logic        bp_branch,
  input  logic [31:0] bp_target,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic        if2_allowin,
  output logic        if1_to_if2_valid,
  output logic [31:0] if1_pc,
  output logic        if1_pred_taken,
  output logic [31:0] if1_pred_target,
  output logic        if1_cancel
);

  typedef enum logic [1:0] {StRstHold, StFetch, StHold} state_t;

  localparam logic [1:0] MaxOut = 2'(MAX_OUTSTANDING);

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic        pending_valid_q, pending_valid_d;
  logic        pending_exc_q, pending_exc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        cancel_d;

  logic        accept;
  logic        data_dec;
  logic        redir_any;
  logic [31:0] redir_target;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] seq_pc;

`ifdef IF1_BP_EN
  assign pred_taken  = bp_branch;
  assign pred_target = bp_target;
`else
  logic unused_bp;
  assign unused_bp   = bp_branch ^ (^bp_target);
  assign pred_taken  = 1'b0;
  assign pred_target = 32'h0;
`endif

  assign bp_pc_low    = fetch_pc_q[7:2];
  assign inst_addr    = fetch_pc_q;
  assign redir_any    = exc_valid || redirect_valid;
  assign redir_target = exc_valid ? exc_pc : redirect_pc;
  assign seq_pc       = pred_taken ? pred_target : fetch_pc_q + 32'd4;
  assign accept       = inst_req && inst_addr_ok;
  assign data_dec     = inst_data_ok && (outstanding_q != 2'd0);

  // Request/state control; HOLD keeps the address stable until the bus takes it.
  always_comb begin
    inst_req = 1'b0;
    state_d  = state_q;
    unique case (state_q)
      StRstHold: state_d = StFetch;
      StFetch: begin
        inst_req = if2_allowin && (outstanding_q < MaxOut) && !redir_any;
        if (inst_req && !inst_addr_ok) state_d = StHold;
      end
      StHold: begin
        inst_req = 1'b1;
        if (inst_addr_ok) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    fetch_pc_d      = fetch_pc_q;
    pending_valid_d = pending_valid_q;
    pending_exc_d   = pending_exc_q;
    pending_pc_d    = pending_pc_q;
    cancel_d        = 1'b0;
    if (accept) begin
      if (redir_any) begin
        fetch_pc_d = redir_target;
        cancel_d   = 1'b1;
      end else if (pending_valid_q) begin
        fetch_pc_d = pending_pc_q;
        cancel_d   = 1'b1;
      end else begin
        fetch_pc_d = seq_pc;
      end
      pending_valid_d = 1'b0;
      pending_exc_d   = 1'b0;
    end else if (state_q == StHold) begin
      // A pending exception must not be displaced by a later, lower-priority redirect.
      if (exc_valid || (redirect_valid && !pending_exc_q)) begin
        pending_valid_d = 1'b1;
        pending_exc_d   = exc_valid;
        pending_pc_d    = redir_target;
      end
    end else if (redir_any) begin
      fetch_pc_d = redir_target;
      cancel_d   = 1'b1;
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !data_dec) outstanding_d = outstanding_q + 2'd1;
    else if (!accept && data_dec) outstanding_d = outstanding_q - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StRstHold;
      fetch_pc_q       <= RESET_PC;
      outstanding_q    <= 2'd0;
      pending_valid_q  <= 1'b0;
      pending_exc_q    <= 1'b0;
      pending_pc_q     <= 32'h0;
      if1_to_if2_valid <= 1'b0;
      if1_pc           <= 32'h0;
      if1_pred_taken   <= 1'b0;
      if1_pred_target  <= 32'h0;
      if1_cancel       <= 1'b0;
    end else begin
      state_q          <= state_d;
      fetch_pc_q       <= fetch_pc_d;
      outstanding_q    <= outstanding_d;
      pending_valid_q  <= pending_valid_d;
      pending_exc_q    <= pending_exc_d;
      pending_pc_q     <= pending_pc_d;
      if1_to_if2_valid <= accept;
      if1_cancel       <= cancel_d;
      if (accept) begin
        if1_pc          <= fetch_pc_q;
        if1_pred_taken  <= pred_taken;
        if1_pred_target <= pred_target;
      end
    end
  end

endmodule

// File: doc/if1_pc_gen.md
Name: if1_pc_gen

Overview:
- Fetch-address generator for stage IF1; sits directly upstream of the BTB predictor (bp) and of the IF2 stage.
- Holds the fetch PC and drives the predictor index from it.
- Selects the next PC: exception entry, EX redirect, predicted-taken target, or sequential PC+4.
- Issues fetch requests on the SRAM-like instruction bus, tracks outstanding requests, and tags each accepted fetch, with its prediction, to IF2.

Parameters:
RESET_PC, 32'h1C000000, fetch PC loaded on reset
MAX_OUTSTANDING, 2, maximum accepted-but-not-returned fetches (1..3)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
bp_pc_low  output  6  predictor index, fetch_pc[7:2]
bp_branch  input  1  predictor: taken
bp_target  input  32  predictor: target
exc_valid  input  1  exception/ertn redirect, one-cycle pulse
exc_pc  input  32  exception/ertn target
redirect_valid  input  1  EX mispredict redirect, one-cycle pulse
redirect_pc  input  32  corrected PC
inst_req  output  1  fetch request
inst_addr  output  32  fetch address
inst_addr_ok  input  1  bus accepted address
inst_data_ok  input  1  bus returned one instruction
if2_allowin  input  1  IF2 can take a new fetch tag
if1_to_if2_valid  output  1  one-cycle tag strobe
if1_pc  output  32  PC of tagged fetch
if1_pred_taken  output  1  prediction used for that fetch
if1_pred_target  output  32  predicted target
if1_cancel  output  1  IF2 must drop all older in-flight fetches

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, state=RST_HOLD, outstanding=0, pending_valid=0, all outputs 0 except inst_addr=RESET_PC and bp_pc_low=RESET_PC[7:2].
- States:
  - RST_HOLD: one cycle after reset release, inst_req=0; then go to FETCH.
  - FETCH: inst_req=1 when if2_allowin && outstanding<MAX_OUTSTANDING && !exc_valid && !redirect_valid; inst_addr=fetch_pc. If inst_req && !inst_addr_ok, go to HOLD.
  - HOLD: inst_req=1 and inst_addr frozen until inst_addr_ok; ignores if2_allowin; on inst_addr_ok go to FETCH.
- Next PC, priority order: exc_pc > redirect_pc > pending_pc > (bp_branch ? bp_target : fetch_pc+4). PC+4 wraps modulo 2^32.
- Accept (inst_req && inst_addr_ok):
  - if1_to_if2_valid=1 next cycle, carrying fetch_pc, bp_branch and bp_target as sampled in the accept cycle.
  - fetch_pc <= next PC; outstanding += 1.
- outstanding:
  - decrements on inst_data_ok.
  - unchanged when accept and data_ok occur in the same cycle.
  - never exceeds MAX_OUTSTANDING; a data_ok with outstanding=0 is ignored.
- Redirect/exception in FETCH with no request held:
  - fetch_pc <= target immediately.
  - if1_cancel=1 next cycle.
  - no request is issued that cycle.
- Redirect/exception in HOLD:
  - latch pending_valid=1, pending_pc=target (exception overwrites a pending redirect; a redirect does not overwrite a pending exception).
  - address stays frozen.
  - on accept, the tag strobe still fires, if1_cancel=1 in the same cycle, fetch_pc <= pending_pc, pending_valid clears.
- if1_cancel is a one-cycle pulse. Simultaneous exc_valid and redirect_valid: exception wins, one cancel.
- bp_pc_low is combinational from fetch_pc (current, not next).

Optional Feature:
IF1_BP_EN
- Defined: bp_branch/bp_target steer next PC as above; the if1_pred_* outputs carry them.
- Undefined: prediction inputs are ignored; next PC is always fetch_pc+4 absent redirect; if1_pred_taken=0 and if1_pred_target=0.

Test Plan:
- Reset release, addr_ok always 1, data_ok one cycle after accept, no prediction -> inst_addr sequence 1C000000, 1C000004, 1C000008; first req in 2nd cycle after reset release; tags match.
- bp_branch=1, bp_target=1C000100 at PC 1C000008 (bp_pc_low=02) -> next inst_addr 1C000100; tag has pred_taken=1, pred_target=1C000100.
- addr_ok held 0 for 3 cycles, redirect_valid to 1C000200 in 2nd held cycle -> inst_addr stays at held value; on accept cancel=1; next inst_addr 1C000200.
- exc_valid (exc_pc=1C008000) and redirect_valid same cycle in FETCH -> one cancel pulse; next inst_addr 1C008000.
- data_ok withheld, MAX_OUTSTANDING=2 -> exactly 2 accepts then inst_req=0; one data_ok -> req resumes next cycle.
- if2_allowin=0 in FETCH -> inst_req=0 and fetch_pc unchanged; async rst asserted in HOLD -> outputs cleared immediately; restart from 1C000000.
